// File: rtl/scroll_refresh_ctrl.sv
// ----------------------------------------------------------------------------
// scroll_refresh_ctrl
//
// Drives the refresh_en / trigger handshake of the game-state FSM. When the
// doodle climbs above THRESH_Y during gameplay, a scroll is requested. Once
// the game enters Refreshing, the world is scrolled down a few rows per frame
// until the captured distance is consumed. Then trigger is pulsed. The
// controller also accumulates the height score in scrolled rows.
//
// Ports:
//   Clock          system clock
//   Reset          synchronous, active-high reset
//   frame_tick     one-cycle pulse per frame (vsync)
//   outstate[2:0]  game state: 000 menu, 001 game, 010 pause, 011 refreshing
//   doodle_y       doodle top row, screen coordinates (0 = top)
//   refresh_en     level request to enter Refreshing
//   trigger        one-cycle pulse, scroll finished
//   scroll_active  high while scrolling
//   scroll_pulse   one-cycle pulse; shift platforms/doodle down by scroll_dy
//   scroll_dy      shift amount, zero outside scroll_pulse
//   score          total rows scrolled since leaving the menu (saturating)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a frame where the doodle is above THRESH_Y
// REQ    | refresh_en held until the game enters Refreshing
// SCROLL | one shift of up to STEP rows per frame_tick
// DONE   | scroll complete; trigger pulses next cycle, then back to IDLE
// ----------------------------------------------------------------------------
module scroll_refresh_ctrl #(
    parameter int THRESH_Y = 160,
    parameter int STEP     = 4,
    parameter int Y_W      = 10
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           frame_tick,
    input  logic [2:0]     outstate,
    input  logic [Y_W-1:0] doodle_y,
    output logic           refresh_en,
    output logic           trigger,
    output logic           scroll_active,
    output logic           scroll_pulse,
    output logic [Y_W-1:0] scroll_dy,
    output logic [15:0]    score
);

    localparam logic [Y_W-1:0] THRESH_C = Y_W'(THRESH_Y);
    localparam logic [Y_W-1:0] STEP_C   = Y_W'(STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SCROLL = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         r_state;
    logic [Y_W-1:0] r_remaining;
    logic           r_refresh_en;
    logic           r_trigger;
    logic           r_scroll_active;
    logic           r_scroll_pulse;
    logic [Y_W-1:0] r_scroll_dy;
    logic [15:0]    r_score;

    logic           w_menu;
    logic           w_game;
    logic           w_refreshing;
    logic [Y_W-1:0] w_dy;
    logic [Y_W-1:0] w_rem_next;
    logic [16:0]    w_score_sum;
    logic [15:0]    w_score_sat;

    assign w_menu       = (outstate == 3'b000);
    assign w_game       = (outstate == 3'b001);
    assign w_refreshing = (outstate == 3'b011);

    assign w_dy        = (r_remaining < STEP_C) ? r_remaining : STEP_C;
    assign w_rem_next  = r_remaining - w_dy;
    assign w_score_sum = {1'b0, r_score} + 17'(w_dy);
    assign w_score_sat = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state         <= IDLE;
            r_remaining     <= '0;
            r_refresh_en    <= 1'b0;
            r_trigger       <= 1'b0;
            r_scroll_active <= 1'b0;
            r_scroll_pulse  <= 1'b0;
            r_scroll_dy     <= '0;
            r_score         <= '0;
        end else begin
            r_trigger      <= 1'b0;
            r_scroll_pulse <= 1'b0;
            r_scroll_dy    <= '0;

            // Menu clear has priority over any increment below; the only
            // increment path is gated by !w_menu.
            if (w_menu) begin
                r_score <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (w_game && frame_tick && (doodle_y < THRESH_C)) begin
                        r_remaining  <= THRESH_C - doodle_y;
                        r_state      <= REQ;
                        r_refresh_en <= 1'b1;
                    end
                end
                REQ: begin
                    // Pause (and game) keep the request pending.
                    if (w_refreshing) begin
                        r_state         <= SCROLL;
                        r_refresh_en    <= 1'b0;
                        r_scroll_active <= 1'b1;
                    end else if (w_menu) begin
                        r_state      <= IDLE;
                        r_remaining  <= '0;
                        r_refresh_en <= 1'b0;
                    end
                end
                SCROLL: begin
                    // Exit to menu wins over a coincident frame_tick.
                    if (w_menu) begin
                        r_state         <= IDLE;
                        r_remaining     <= '0;
                        r_scroll_active <= 1'b0;
                    end else if (frame_tick) begin
                        r_scroll_pulse <= 1'b1;
                        r_scroll_dy    <= w_dy;
                        r_remaining    <= w_rem_next;
                        r_score        <= w_score_sat;
                        if (w_rem_next == '0) begin
                            r_state         <= DONE;
                            r_scroll_active <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Entered together with the final pulse, so trigger
                    // lands one cycle after it.
                    r_trigger <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign refresh_en    = r_refresh_en;
    assign trigger       = r_trigger;
    assign scroll_active = r_scroll_active;
    assign scroll_pulse  = r_scroll_pulse;
    assign scroll_dy     = r_scroll_dy;
    assign score         = r_score;

endmodule

// File: tb/tb_scroll_refresh_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for scroll_refresh_ctrl. Stimulus tasks compute the expected pulse
// sequence for each scroll from the captured distance. The sequence is split
// into chunks of at most STEP rows, followed by a trigger. It is queued
// here; a monitor pops an entry whenever the DUT shows scroll_pulse or
// trigger.
// ----------------------------------------------------------------------------
module tb_scroll_refresh_ctrl;

    localparam int THRESH_Y = 160;
    localparam int STEP     = 4;
    localparam int Y_W      = 10;

    logic           Clock = 1'b0;
    logic           Reset;
    logic           frame_tick;
    logic [2:0]     outstate;
    logic [Y_W-1:0] doodle_y;
    logic           refresh_en;
    logic           trigger;
    logic           scroll_active;
    logic           scroll_pulse;
    logic [Y_W-1:0] scroll_dy;
    logic [15:0]    score;

    scroll_refresh_ctrl #(
        .THRESH_Y(THRESH_Y),
        .STEP    (STEP),
        .Y_W     (Y_W)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .outstate     (outstate),
        .doodle_y     (doodle_y),
        .refresh_en   (refresh_en),
        .trigger      (trigger),
        .scroll_active(scroll_active),
        .scroll_pulse (scroll_pulse),
        .scroll_dy    (scroll_dy),
        .score        (score)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit is_trig;
        int dy;
        int sc;
    } ev_t;

    ev_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  m_score  = 0;
    bit  prev_pulse = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle with the given frame_tick; returns just after the edge.
    task automatic step(input bit tk);
        frame_tick = tk;
        @(posedge Clock);
        #1;
        frame_tick = 1'b0;
    endtask

    // Expected pulses for a scroll of THRESH_Y - y rows, up to max_p pulses;
    // the trigger is queued only if the scroll completes.
    task automatic push_scroll(input int y, input int max_p, output int n);
        int rem;
        int dy;
        rem = THRESH_Y - y;
        n = 0;
        while (rem > 0 && n < max_p) begin
            dy = (rem < STEP) ? rem : STEP;
            rem -= dy;
            m_score = (m_score + dy > 65535) ? 65535 : m_score + dy;
            q.push_back('{1'b0, dy, m_score});
            n++;
        end
        if (rem == 0) q.push_back('{1'b1, 0, 0});
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge Clock);
            k++;
        end
        chk("scoreboard_drain", q.size(), 0);
        @(posedge Clock);
        #1;
    endtask

    task automatic run_ticks(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) step(1'b0);
            end
            step(1'b1);
            chk("pulse_latency", scroll_pulse, 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_refresh_en"}, refresh_en, 0);
        chk({tag, "_trigger"}, trigger, 0);
        chk({tag, "_scroll_active"}, scroll_active, 0);
        chk({tag, "_scroll_pulse"}, scroll_pulse, 0);
        chk({tag, "_scroll_dy"}, scroll_dy, 0);
        chk({tag, "_score"}, score, 0);
    endtask

    always @(negedge Clock) begin
        if (Reset) begin
            prev_pulse = 1'b0;
        end else begin
            if (scroll_pulse || trigger) begin
                if (q.size() == 0) begin
                    chk("unexpected_event", {30'd0, scroll_pulse, trigger}, 0);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.is_trig) begin
                        chk("trigger", trigger, 1);
                        chk("trigger_no_pulse", scroll_pulse, 0);
                        chk("trigger_after_last_pulse", prev_pulse, 1);
                    end else begin
                        chk("pulse_seen", scroll_pulse, 1);
                        chk("pulse_dy", scroll_dy, e.dy);
                        chk("pulse_score", score, e.sc);
                    end
                end
            end else begin
                chk("dy_zero_idle", scroll_dy, 0);
            end
            prev_pulse = scroll_pulse;
        end
    end

    initial begin
        int n;
        int y;

        Reset      = 1'b1;
        frame_tick = 1'b0;
        outstate   = 3'b000;
        doodle_y   = '0;
        step(1'b0);
        step(1'b0);
        Reset = 1'b0;
        check_all_zero("reset");

        // Basic scroll from row 150: 4, 4, 2.
        outstate = 3'b001;
        doodle_y = 10'd150;
        step(1'b1);
        chk("basic_refresh_en", refresh_en, 1);
        push_scroll(150, 1000, n);
        outstate = 3'b011;
        step(1'b0);
        chk("basic_refresh_en_drop", refresh_en, 0);
        chk("basic_scroll_active", scroll_active, 1);
        step(1'b1);
        chk("basic_pulse1", scroll_pulse, 1);
        step(1'b0);
        chk("basic_gap_no_pulse", scroll_pulse, 0);
        run_ticks(n - 1, 1'b0);
        drain();
        chk("basic_score", score, 10);
        chk("basic_active_off", scroll_active, 0);

        // Menu clears the score.
        outstate = 3'b000;
        step(1'b0);
        m_score = 0;
        chk("menu_score_clear", score, 0);

        // No request at or below the threshold.
        outstate = 3'b001;
        doodle_y = 10'd160;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("noreq_160", refresh_en, 0);
        end
        doodle_y = 10'd300;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("noreq_300", refresh_en, 0);
        end

        // Pause keeps the request pending.
        doodle_y = 10'd100;
        step(1'b1);
        chk("pause_capture", refresh_en, 1);
        outstate = 3'b010;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("pause_refresh_en", refresh_en, 1);
            chk("pause_no_active", scroll_active, 0);
        end
        push_scroll(100, 1000, n);
        chk("pause_pulse_count", n, 15);
        outstate = 3'b011;
        step(1'b0);
        run_ticks(n, 1'b1);
        drain();
        chk("pause_score", score, 60);

        // Menu during REQ drops the request.
        outstate = 3'b001;
        doodle_y = 10'd120;
        step(1'b1);
        chk("menureq_capture", refresh_en, 1);
        outstate = 3'b000;
        step(1'b0);
        m_score = 0;
        chk("menureq_refresh_drop", refresh_en, 0);
        chk("menureq_score", score, 0);

        // Single-row scroll, with a frame_tick in the DONE cycle.
        outstate = 3'b001;
        doodle_y = 10'(THRESH_Y - 1);
        step(1'b1);
        chk("edge_capture", refresh_en, 1);
        push_scroll(THRESH_Y - 1, 1000, n);
        outstate = 3'b011;
        step(1'b0);
        step(1'b1);
        chk("edge_pulse", scroll_pulse, 1);
        chk("edge_dy", scroll_dy, 1);
        outstate = 3'b001;
        doodle_y = 10'd150;
        step(1'b1);
        chk("edge_trigger", trigger, 1);
        chk("edge_no_extra_pulse", scroll_pulse, 0);
        chk("edge_no_rearm", refresh_en, 0);
        doodle_y = 10'd200;
        step(1'b0);
        chk("edge_no_rearm_late", refresh_en, 0);
        drain();

        // Reset after two pulses of a long scroll.
        doodle_y = 10'd100;
        step(1'b1);
        push_scroll(100, 2, n);
        outstate = 3'b011;
        step(1'b0);
        run_ticks(2, 1'b0);
        Reset = 1'b1;
        step(1'b0);
        Reset = 1'b0;
        q.delete();
        m_score = 0;
        check_all_zero("midreset");
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            chk("midreset_no_pulse", scroll_pulse, 0);
            chk("midreset_no_trigger", trigger, 0);
        end

        // Random scrolls with pauses, gaps and menu visits.
        for (int it = 0; it < 25; it++) begin
            y = $urandom_range(0, 320);
            outstate = 3'b001;
            doodle_y = 10'(y);
            step(1'b1);
            if (y < THRESH_Y) begin
                chk("rnd_capture", refresh_en, 1);
                push_scroll(y, 1000, n);
                outstate = 3'b010;
                for (int p = 0; p < int'($urandom_range(0, 3)); p++) begin
                    step(1'($urandom_range(0, 1)));
                    chk("rnd_pause_hold", refresh_en, 1);
                end
                outstate = 3'b011;
                step(1'b0);
                run_ticks(n, 1'b1);
                drain();
                chk("rnd_score", score, m_score);
            end else begin
                chk("rnd_noreq", refresh_en, 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                outstate = 3'b000;
                step(1'b0);
                m_score = 0;
                chk("rnd_menu_clear", score, 0);
            end
        end

        step(1'b0);
        chk("final_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scroll_refresh_ctrl.md
Name: scroll_refresh_ctrl

Overview:
- Generates the `refresh_en` and `trigger` inputs of the game-state FSM.
- Detects when the doodle climbs above a screen threshold during gameplay and requests the Refreshing state.
- While Refreshing, scrolls the world down over successive frames. Each frame it emits a shift amount that the platform store and doodle position logic consume.
- When the scroll completes, pulses `trigger` so the game returns to Game. It also keeps the height score.

Parameters:
- THRESH_Y, 160, screen row (0 = top); a doodle above this row (y < THRESH_Y) requests a scroll.
- STEP, 4, maximum rows scrolled per frame.
- Y_W, 10, width of screen-row quantities.

Ports:
- Clock  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (vsync)
- outstate  in  3  game state: 000 Main_Menu, 001 Game, 010 Pause, 011 Refreshing
- doodle_y  in  Y_W  doodle top row, screen coordinates
- refresh_en  out  1  level request to enter Refreshing
- trigger  out  1  one-cycle pulse: scroll finished
- scroll_active  out  1  high in SCROLL state
- scroll_pulse  out  1  one-cycle pulse; shift all platforms/doodle down by scroll_dy
- scroll_dy  out  Y_W  shift amount, valid only while scroll_pulse=1, else 0
- score  out  16  total rows scrolled since leaving menu

Behaviour:
- All outputs are registered. Reset value of every output is 0; the FSM resets to IDLE and `remaining` to 0. Reset overrides everything, including mid-scroll.
- Internal register `remaining` (Y_W bits) holds the rows still to scroll.
- IDLE:
  - If outstate==001 and frame_tick and doodle_y < THRESH_Y: capture remaining = THRESH_Y - doodle_y (always >= 1) and go to REQ.
  - No other input causes a transition.
- REQ:
  - refresh_en=1 for the whole state.
  - outstate==011 -> SCROLL.
  - outstate==000 -> IDLE with remaining cleared.
  - outstate==010 or 001 -> stay in REQ. Pause keeps the request pending; it takes effect after resume.
  - frame_tick is ignored.
- SCROLL:
  - scroll_active=1.
  - On frame_tick, in one cycle:
    - dy = min(STEP, remaining)
    - scroll_pulse=1 and scroll_dy=dy, valid the cycle after the tick
    - remaining -= dy
    - score = score + dy, saturating at 16'hFFFF
  - If the new remaining is 0, go to DONE.
  - outstate==000 -> IDLE with remaining cleared.
- DONE:
  - trigger=1 for exactly one cycle, then go to IDLE.
  - frame_tick in DONE is ignored (no pulse).
- Timing:
  - refresh_en rises the cycle after the capturing frame_tick.
  - The first scroll_pulse appears one cycle after the first frame_tick seen in SCROLL.
  - trigger is asserted in the cycle after the final scroll_pulse.
- score clears to 0 on any cycle with outstate==000. This takes priority over a coincident increment.
- scroll_dy width rule: STEP <= THRESH_Y < 2^Y_W; the subtraction never underflows.
- Simultaneous events:
  - frame_tick coinciding with a state-exit condition: the exit wins and no pulse is emitted.
  - A new threshold crossing while not in IDLE is ignored; the doodle is re-tested in IDLE on the next frame_tick.

Test Plan:
- Basic scroll: outstate=001, doodle_y=150, frame_tick -> refresh_en=1. Then set outstate=011 and give 3 ticks -> scroll_pulse with scroll_dy 4, 4, 2; trigger one cycle after the 3rd pulse; score=10; refresh_en=0 after REQ exit.
- No request: doodle_y=160 and then 300 with outstate=001 over 5 ticks -> refresh_en, scroll_pulse and trigger stay 0.
- Pause while requested: doodle_y=100 captured, outstate=010 for 5 ticks -> refresh_en stays 1, no pulses. Then outstate=011 -> 15 pulses of 4, trigger, score=60.
- Reset mid-scroll: after 2 pulses assert Reset one cycle -> all outputs 0, score=0, and no trigger on subsequent ticks with outstate=011.
- Menu clears: score=10, outstate=000 one cycle -> score=0. In REQ, outstate=000 -> refresh_en=0 the next cycle.
- Edge conditions: capture with doodle_y=THRESH_Y-1 -> single pulse, scroll_dy=1, then trigger. A frame_tick in the DONE cycle produces no extra pulse and does not re-arm.
